reg_divider_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/reg_divider_unit_if.sv | 26 ++
 rtl/div_step.sv | 25 ++
 rtl/reg_divider_unit.sv | 128 ++++++++++++
 tb/tb_reg_divider_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, divider state encoding and magnitude helper
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    // Two's-complement magnitude when the operand is signed and negative.
    // The most negative value maps onto itself, which the unsigned datapath
    // then reads as 2^(XLEN-1), its true magnitude.
    function automatic logic [XLEN-1:0] abs2c(input logic [XLEN-1:0] value,
                                              input logic is_signed);
        if (is_signed && value[XLEN-1]) begin
            return ~value + 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/reg_divider_unit_if.sv
// rtl/reg_divider_unit_if.sv - issue/writeback bundle between issue logic and divider
interface reg_divider_unit_if #(
    parameter int WIDTH = cpu_pkg::XLEN
);
    logic                            Start;
    logic                            IsSigned;
    logic [WIDTH-1:0]                BusA;
    logic [WIDTH-1:0]                BusB;
    logic [cpu_pkg::REG_ADDR_W-1:0]  Rd;
    logic                            Ready;
    logic                            Done;
    logic [WIDTH-1:0]                BusW;
    logic [cpu_pkg::REG_ADDR_W-1:0]  RW;
    logic                            RegWr;

    modport master (
        output Start, IsSigned, BusA, BusB, Rd,
        input  Ready, Done, BusW, RW, RegWr
    );

    modport slave (
        input  Start, IsSigned, BusA, BusB, Rd,
        output Ready, Done, BusW, RW, RegWr
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift, compare, subtract
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    // The remainder stays below the divisor, so its top bit is never set; if
    // it ever were, the shifted value would certainly exceed the divisor.
    assign fits    = rem[WIDTH] | (shifted >= {1'b0, divisor});

    assign rem_next = fits ? diff : shifted;
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/reg_divider_unit.sv
// rtl/reg_divider_unit.sv - iterative UDIV/SDIV unit writing the quotient to the register file
module reg_divider_unit #(
    parameter int                               WIDTH    = cpu_pkg::XLEN,
    parameter logic [cpu_pkg::REG_ADDR_W-1:0]   ZERO_REG = 5'd31
) (
    input  logic              Clk,
    input  logic              Reset,
    reg_divider_unit_if.slave bus
);
    import cpu_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t state, state_next;

    logic [WIDTH:0]          rem_q, rem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [WIDTH-1:0]        dvs_q, dvs_d;
    logic                    neg_q, neg_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic [WIDTH-1:0]        busw_q, busw_d;
    logic                    regwr_q, regwr_d;

    logic [WIDTH:0]          step_rem;
    logic [WIDTH-1:0]        step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the datapath and result values it implies.
    always_comb begin
        state_next = state;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_d      = neg_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        busw_d     = '0;
        regwr_d    = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (bus.Start) begin
                    quo_d = abs2c(bus.BusA, bus.IsSigned);
                    dvs_d = abs2c(bus.BusB, bus.IsSigned);
                    neg_d = bus.IsSigned && (bus.BusA[WIDTH-1] ^ bus.BusB[WIDTH-1]);
                    rd_d  = bus.Rd;
                    rem_d = '0;
                    cnt_d = CW'(WIDTH);
                    if (bus.BusB == '0) begin
                        // Division by zero yields 0 immediately, no iterations.
                        state_next = DIV_DONE;
                        done_d     = 1'b1;
                        regwr_d    = (bus.Rd != ZERO_REG);
                    end else begin
                        state_next = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_next = DIV_DONE;
                    done_d     = 1'b1;
                    busw_d     = neg_q ? (~step_quo + 1'b1) : step_quo;
                    regwr_d    = (rd_q != ZERO_REG);
                end
            end
            DIV_DONE: begin
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    // Operand/iteration registers and the registered writeback outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busw_q  <= '0;
            regwr_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busw_q  <= busw_d;
            regwr_q <= regwr_d;
        end
    end

    assign bus.Ready = (state == DIV_IDLE);
    assign bus.Done  = done_q;
    assign bus.BusW  = busw_q;
    assign bus.RW    = rd_q;
    assign bus.RegWr = regwr_q;

endmodule

// File: tb/tb_reg_divider_unit.sv
// tb/tb_reg_divider_unit.sv - self-checking bench for reg_divider_unit
module tb_reg_divider_unit;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reg_divider_unit_if #(.WIDTH(64)) bus ();

    reg_divider_unit #(.WIDTH(64), .ZERO_REG(5'd31)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    // Quotient from sign/magnitude arithmetic; divide by zero gives 0.
    function automatic logic [63:0] ref_quot(input logic s, input logic [63:0] a,
                                             input logic [63:0] b);
        logic [63:0] ma, mb, q;
        if (b == 64'd0) return 64'd0;
        ma = (s && a[63]) ? (64'd0 - a) : a;
        mb = (s && b[63]) ? (64'd0 - b) : b;
        q  = ma / mb;
        if (s && (a[63] != b[63])) q = 64'd0 - q;
        return q;
    endfunction

    // Issues one op and waits for Done; cyc=0 means Done never came.
    task automatic run_op(input logic s, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, output int cyc, output logic [63:0] q,
                          output logic [4:0] rw, output logic wr);
        int w;
        w = 0; cyc = 0; q = '0; rw = '0; wr = 1'b0;
        @(negedge clk);
        while (!bus.Ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        bus.Start = 1'b1; bus.IsSigned = s; bus.BusA = a; bus.BusB = b; bus.Rd = rd;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (bus.Done) begin
                cyc = n; q = bus.BusW; rw = bus.RW; wr = bus.RegWr;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.Ready !== 1'b1 || bus.Done !== 1'b0 || bus.RegWr !== 1'b0 ||
            bus.BusW !== 64'd0 || bus.RW !== 5'd0) begin
            errors++;
            $display("FAIL reset: got ready=%b done=%b regwr=%b busw=%0h rw=%0d expected 1 0 0 0 0",
                     bus.Ready, bus.Done, bus.RegWr, bus.BusW, bus.RW);
        end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        @(negedge clk);
        bus.Start = 1'b1; bus.IsSigned = 1'b0; bus.BusA = 64'd100; bus.BusB = 64'd7; bus.Rd = 5'd5;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int n = 1; n <= 66; n++) begin
            checks++;
            if (bus.Ready !== (n == 66) || bus.Done !== (n == 65)) begin
                errors++;
                $display("FAIL latency cycle %0d: got ready=%b done=%b expected %b %b",
                         n, bus.Ready, bus.Done, (n == 66), (n == 65));
            end
            if (n == 65) begin
                checks++;
                if (bus.BusW !== 64'd14 || bus.RW !== 5'd5 || bus.RegWr !== 1'b1) begin
                    errors++;
                    $display("FAIL udiv_100_7: got busw=%0d rw=%0d regwr=%b expected 14 5 1",
                             bus.BusW, bus.RW, bus.RegWr);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_signed_and_edges();
        logic        s_t [6] = '{1, 1, 1, 0, 1, 0};
        logic [63:0] a_t [6] = '{-64'sd100, 64'd100, -64'sd100, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h8000_0000_0000_0000, 64'd20};
        logic [63:0] b_t [6] = '{64'd7, -64'sd7, -64'sd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4};
        logic [63:0] q_t [6] = '{64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFF2, 64'd14,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd5};
        logic [4:0]  r_t [6] = '{5'd9, 5'd1, 5'd2, 5'd4, 5'd6, 5'd31};
        int cyc; logic [63:0] q; logic [4:0] rw; logic wr;
        for (int i = 0; i < 6; i++) begin
            run_op(s_t[i], a_t[i], b_t[i], r_t[i], cyc, q, rw, wr);
            checks++;
            if (cyc !== 65 || q !== q_t[i] || rw !== r_t[i] || wr !== (r_t[i] != 5'd31)) begin
                errors++;
                $display("FAIL fixed_case_%0d: got cyc=%0d q=%0h rw=%0d wr=%b expected 65 %0h %0d %b",
                         i, cyc, q, rw, wr, q_t[i], r_t[i], (r_t[i] != 5'd31));
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc; logic [63:0] q; logic [4:0] rw; logic wr;
        for (int s = 0; s < 2; s++) begin
            run_op(s[0], {$urandom, $urandom}, 64'd0, 5'd3, cyc, q, rw, wr);
            checks++;
            if (cyc !== 1 || q !== 64'd0 || rw !== 5'd3 || wr !== 1'b1) begin
                errors++;
                $display("FAIL div_zero signed=%0d: got cyc=%0d q=%0h rw=%0d wr=%b expected 1 0 3 1",
                         s, cyc, q, rw, wr);
            end
        end
    endtask

    task automatic test_start_held();
        int          done_cyc [$];
        logic [63:0] done_val [$];
        @(negedge clk);
        while (!bus.Ready) @(negedge clk);
        bus.Start = 1'b1; bus.IsSigned = 1'b0; bus.BusA = 64'd1000; bus.BusB = 64'd10; bus.Rd = 5'd7;
        @(negedge clk);
        for (int n = 1; n <= 140; n++) begin
            if (n == 20) begin
                bus.IsSigned = 1'b1; bus.BusA = -64'sd999; bus.BusB = 64'd3; bus.Rd = 5'd8;
            end
            if (n == 67) bus.Start = 1'b0;
            if (n == 66) begin
                checks++;
                if (bus.Ready !== 1'b1) begin
                    errors++;
                    $display("FAIL held_ready_66: got %b expected 1", bus.Ready);
                end
            end
            if (bus.Done) begin
                done_cyc.push_back(n);
                done_val.push_back(bus.BusW);
            end
            @(negedge clk);
        end
        checks++;
        if (done_cyc.size() != 2) begin
            errors++;
            $display("FAIL held_done_count: got %0d expected 2", done_cyc.size());
        end else if (done_cyc[0] != 65 || done_val[0] !== 64'd100 ||
                     done_cyc[1] != 131 || done_val[1] !== ref_quot(1'b1, -64'sd999, 64'd3)) begin
            errors++;
            $display("FAIL held_results: got %0d/%0h %0d/%0h expected 65/64 131/%0h",
                     done_cyc[0], done_val[0], done_cyc[1], done_val[1],
                     ref_quot(1'b1, -64'sd999, 64'd3));
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic [63:0] q; logic [4:0] rw; logic wr;
        logic seen;
        @(negedge clk);
        while (!bus.Ready) @(negedge clk);
        bus.Start = 1'b1; bus.IsSigned = 1'b0; bus.BusA = 64'd100000; bus.BusB = 64'd3; bus.Rd = 5'd12;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.Ready !== 1'b1 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready: got ready=%b done=%b expected 1 0", bus.Ready, bus.Done);
        end
        seen = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (bus.Done || bus.RegWr) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got done seen=%b expected 0", seen);
        end
        reset = 1'b1; bus.Start = 1'b1; bus.IsSigned = 1'b0; bus.BusA = 64'd50; bus.BusB = 64'd5;
        @(negedge clk);
        reset = 1'b0; bus.Start = 1'b0;
        checks++;
        if (bus.Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_start_same: got ready=%b expected 1", bus.Ready);
        end
        run_op(1'b0, 64'd9, 64'd3, 5'd10, cyc, q, rw, wr);
        checks++;
        if (cyc !== 65 || q !== 64'd3 || wr !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_9_3: got cyc=%0d q=%0d wr=%b expected 65 3 1", cyc, q, wr);
        end
    endtask

    task automatic test_random();
        int cyc; logic [63:0] q; logic [4:0] rw; logic wr;
        logic s; logic [63:0] a, b; logic [4:0] rd;
        for (int i = 0; i < 24; i++) begin
            s  = $urandom_range(0, 1);
            a  = {$urandom, $urandom};
            rd = $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0: b = 64'd0;
                1: b = ($urandom_range(0, 1) != 0) ? 64'd0 - 64'($urandom_range(1, 20))
                                                   : 64'($urandom_range(1, 20));
                2: b = {$urandom, $urandom};
                default: b = (a >> $urandom_range(1, 62)) | 64'd1;
            endcase
            run_op(s, a, b, rd, cyc, q, rw, wr);
            checks++;
            if (cyc !== ((b == 64'd0) ? 1 : 65) || q !== ref_quot(s, a, b) ||
                rw !== rd || wr !== (rd != 5'd31)) begin
                errors++;
                $display("FAIL random_%0d s=%b a=%0h b=%0h: got cyc=%0d q=%0h rw=%0d wr=%b expected q=%0h rw=%0d",
                         i, s, a, b, cyc, q, rw, wr, ref_quot(s, a, b), rd);
            end
        end
    endtask

    initial begin
        bus.Start = 1'b0; bus.IsSigned = 1'b0; bus.BusA = '0; bus.BusB = '0; bus.Rd = '0;
        reset = 1'b0;
        test_reset();
        test_latency();
        test_signed_and_edges();
        test_div_zero();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
